divider_32: RTL

Sequential 32-bit restoring divider, the inverse companion to the shift-add multiplier in the processor's execute stage. It accepts a dividend and divisor on a start pulse and produces one quotient bit per enabled clock. It then presents the quotient, the remainder and a done flag until the next start. The execute stage uses the same `ena`/done handshake as for multiplication.

---
 rtl/divider_32_if.sv | 22 ++
 rtl/divider_32.sv | 112 +++++++++++
 2 files changed

// File: rtl/divider_32_if.sv
// divider_32_if: operand/result bundle between the execute stage and the
// sequential divider. The execute stage is the master.
// Optional build macro: DIVIDER_32_SIGNED_EN adds the sgn operand qualifier.
interface divider_32_if;
  logic        ena;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] q;
  logic [31:0] r;
  logic        dne;
  logic        dbz;
`ifdef DIVIDER_32_SIGNED_EN
  logic        sgn;

  modport master (output ena, start, a, b, sgn, input q, r, dne, dbz);
  modport slave  (input ena, start, a, b, sgn, output q, r, dne, dbz);
`else
  modport master (output ena, start, a, b, input q, r, dne, dbz);
  modport slave  (input ena, start, a, b, output q, r, dne, dbz);
`endif
endinterface

// File: rtl/divider_32.sv
// divider_32: 32-bit restoring divider, one quotient bit per enabled clock.
// Start at enabled edge E0, result and dne at E32 (E1 for divide-by-zero).
// Optional build macro: DIVIDER_32_SIGNED_EN (two's complement operands when
// sgn=1; magnitudes are divided and the signs fixed up on the final write).
module divider_32 (
  input  logic           clk,
  input  logic           rst,
  divider_32_if.slave    bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} st_t;

  st_t         st, st_nx;
  logic [31:0] dvd;      // dividend shifting out, quotient shifting in
  logic [31:0] dvs;      // divisor magnitude
  logic [31:0] rem;      // partial remainder (always < dvs, so 32 bits hold it)
  logic [31:0] a_sav;    // raw dividend, returned as r on divide-by-zero
  logic [5:0]  cnt;
  logic        zdiv;
  logic        neg_q, neg_r;
  logic [31:0] q_o, r_o;
  logic        dne_o, dbz_o;

  // operand sign handling at start
  logic        sa, sb;
  logic [31:0] mag_a, mag_b;
`ifdef DIVIDER_32_SIGNED_EN
  assign sa = bus.sgn & bus.a[31];
  assign sb = bus.sgn & bus.b[31];
`else
  assign sa = 1'b0;
  assign sb = 1'b0;
`endif
  assign mag_a = sa ? (32'd0 - bus.a) : bus.a;
  assign mag_b = sb ? (32'd0 - bus.b) : bus.b;

  // one restoring step: 33-bit shifted remainder against the divisor
  logic [32:0] rem_sh, diff;
  logic        ge, last, fin;
  logic [31:0] rem_nx, dvd_nx, res_q, res_r;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) st <= IDLE;
    else      st <= st_nx;
  end

  // Next-state: start wins from any state; RUN exits on zero divisor or step 32
  always_comb begin
    st_nx = st;
    if (bus.ena) begin
      if (bus.start)                        st_nx = RUN;
      else if (st == RUN && (zdiv || last)) st_nx = DONE;
    end
  end

  // Output/step logic: trial subtract and final result with sign fixup
  always_comb begin
    rem_sh = {rem, dvd[31]};
    diff   = rem_sh - {1'b0, dvs};
    // a set MSB means the shifted remainder already exceeds any 32-bit divisor
    ge     = rem_sh[32] | ~diff[32];
    rem_nx = ge ? diff[31:0] : rem_sh[31:0];
    dvd_nx = {dvd[30:0], ge};
    last   = (cnt == 6'd31);
    fin    = bus.ena && !bus.start && (st == RUN) && (zdiv || last);
    res_q  = '1;
    res_r  = a_sav;
    if (!zdiv) begin
      res_q = neg_q ? (32'd0 - dvd_nx) : dvd_nx;
      res_r = neg_r ? (32'd0 - rem_nx) : rem_nx;
    end
  end

  // Datapath and result registers; ena=0 freezes everything
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dvd <= '0; dvs <= '0; rem <= '0; a_sav <= '0; cnt <= '0;
      zdiv <= 1'b0; neg_q <= 1'b0; neg_r <= 1'b0;
      q_o <= '0; r_o <= '0; dne_o <= 1'b0; dbz_o <= 1'b0;
    end else if (bus.ena) begin
      if (bus.start) begin
        dvd   <= mag_a;
        dvs   <= mag_b;
        a_sav <= bus.a;
        rem   <= '0;
        cnt   <= '0;
        zdiv  <= (bus.b == 32'd0);
        neg_q <= sa ^ sb;
        neg_r <= sa;
        dne_o <= 1'b0;
        dbz_o <= 1'b0;
      end else if (st == RUN) begin
        dvd <= dvd_nx;
        rem <= rem_nx;
        cnt <= cnt + 6'd1;
        if (fin) begin
          q_o   <= res_q;
          r_o   <= res_r;
          dne_o <= 1'b1;
          dbz_o <= zdiv;
        end
      end
    end
  end

  assign bus.q   = q_o;
  assign bus.r   = r_o;
  assign bus.dne = dne_o;
  assign bus.dbz = dbz_o;

endmodule
